// File: rtl/maxigp_pkg.sv
// Shared types and constants for the MAXIGP0 request scheduler.
package maxigp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      WR      = 2'd2,
      WR_RESP = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int AXI_DATA_W = 32;
   localparam int AXI_LEN_W  = 4;

endpackage

// File: rtl/maxigp_req_scheduler_if.sv
// Bundle of the AXI3 slave channels plus the single-ported target request port.
// slave modport: scheduler side; master modport: AXI master + target side.
interface maxigp_req_scheduler_if #(
   parameter int ADDR_W = 18,
   parameter int ID_W   = 12
);
   import maxigp_pkg::*;

   logic [31:0]            ar_addr;
   logic [ID_W-1:0]        ar_id;
   logic [AXI_LEN_W-1:0]   ar_len;
   logic                   ar_valid;
   logic                   ar_ready;

   logic [AXI_DATA_W-1:0]  r_data;
   logic [ID_W-1:0]        r_id;
   logic [1:0]             r_resp;
   logic                   r_last;
   logic                   r_valid;
   logic                   r_ready;

   logic [31:0]            aw_addr;
   logic [ID_W-1:0]        aw_id;
   logic [AXI_LEN_W-1:0]   aw_len;
   logic                   aw_valid;
   logic                   aw_ready;

   logic [AXI_DATA_W-1:0]  w_data;
   logic                   w_last;
   logic                   w_valid;
   logic                   w_ready;

   logic [ID_W-1:0]        b_id;
   logic [1:0]             b_resp;
   logic                   b_valid;
   logic                   b_ready;

   logic                   req_valid;
   logic                   req_write;
   logic [ADDR_W-1:0]      req_addr;
   logic [AXI_DATA_W-1:0]  req_wdata;
   logic                   req_ready;

   logic                   rsp_valid;
   logic [AXI_DATA_W-1:0]  rsp_data;

   modport slave (
      input  ar_addr, ar_id, ar_len, ar_valid,
      output ar_ready,
      output r_data, r_id, r_resp, r_last, r_valid,
      input  r_ready,
      input  aw_addr, aw_id, aw_len, aw_valid,
      output aw_ready,
      input  w_data, w_last, w_valid,
      output w_ready,
      output b_id, b_resp, b_valid,
      input  b_ready,
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_data
   );

   modport master (
      output ar_addr, ar_id, ar_len, ar_valid,
      input  ar_ready,
      input  r_data, r_id, r_resp, r_last, r_valid,
      output r_ready,
      output aw_addr, aw_id, aw_len, aw_valid,
      input  aw_ready,
      output w_data, w_last, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_valid,
      output b_ready,
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_data
   );

endinterface

// File: rtl/maxigp_rsp_fifo.sv
// Synchronous read-response FIFO; head is visible combinationally while not empty.
module maxigp_rsp_fifo
   import maxigp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = AXI_DATA_W
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W:0]   wr_ptr_r;
   logic [PTR_W:0]   rd_ptr_r;
   logic             full_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                      (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign push_ok_s = push & ~full_s;
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r[PTR_W-1:0]];

   // Storage array write; contents need no reset because pointers gate visibility.
   always_ff @(posedge CLK) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
      end
   end

   // Read/write pointer advance; reset empties the FIFO.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/maxigp_req_scheduler.sv
// MAXIGP0 AXI3 slave to single-ported word-request scheduler.
// Optional macro MAXIGP_ADDR_DECODE_EN: bursts with nonzero address bits above
// the target window are answered locally with SLVERR and never reach the target.
module maxigp_req_scheduler
   import maxigp_pkg::*;
#(
   parameter int ADDR_W    = 18,
   parameter int ID_W      = 12,
   parameter int RSP_DEPTH = 4
)(
   input  logic                 CLK,
   input  logic                 RST,
   maxigp_req_scheduler_if.slave bus
);

   localparam int                CRED_W   = $clog2(RSP_DEPTH) + 1;
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RSP_DEPTH);
   localparam int                CNT_W    = AXI_LEN_W + 1;

   state_t                state_r;
   state_t                state_s;
   logic                  rd_first_r;
   logic [ADDR_W-1:0]     addr_r;
   logic [ID_W-1:0]       id_r;
   logic [AXI_LEN_W-1:0]  len_r;
   logic [AXI_LEN_W-1:0]  beat_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [CRED_W-1:0]     credits_r;
   logic                  err_r;
   logic                  oor_r;

   logic                  grant_rd_s;
   logic                  grant_wr_s;
   logic                  ar_oor_s;
   logic                  aw_oor_s;
   logic                  ar_ready_s;
   logic                  aw_ready_s;
   logic                  r_valid_s;
   logic                  r_last_s;
   logic [1:0]            r_resp_s;
   logic [AXI_DATA_W-1:0] r_data_s;
   logic                  w_ready_s;
   logic                  b_valid_s;
   logic [1:0]            b_resp_s;
   logic                  req_valid_s;
   logic                  req_write_s;
   logic [AXI_DATA_W-1:0] req_wdata_s;
   logic                  ar_hs_s;
   logic                  aw_hs_s;
   logic                  req_hs_s;
   logic                  rd_req_hs_s;
   logic                  w_hs_s;
   logic                  r_hs_s;
   logic                  b_hs_s;
   logic                  fifo_push_s;
   logic                  fifo_pop_s;
   logic                  fifo_empty_s;
   logic [AXI_DATA_W-1:0] fifo_head_s;
   logic                  unused_addr_bits_s;

`ifdef MAXIGP_ADDR_DECODE_EN
   assign ar_oor_s           = |bus.ar_addr[31:ADDR_W+2];
   assign aw_oor_s           = |bus.aw_addr[31:ADDR_W+2];
   assign unused_addr_bits_s = ^{bus.ar_addr[1:0], bus.aw_addr[1:0]};
`else
   assign ar_oor_s           = 1'b0;
   assign aw_oor_s           = 1'b0;
   assign unused_addr_bits_s = ^{bus.ar_addr[31:ADDR_W+2], bus.ar_addr[1:0],
                                 bus.aw_addr[31:ADDR_W+2], bus.aw_addr[1:0]};
`endif

   // Round-robin between the channels only when both request at once.
   assign grant_rd_s = bus.ar_valid & (~bus.aw_valid | rd_first_r);
   assign grant_wr_s = bus.aw_valid & (~bus.ar_valid | ~rd_first_r);

   assign ar_hs_s     = bus.ar_valid & ar_ready_s;
   assign aw_hs_s     = bus.aw_valid & aw_ready_s;
   assign req_hs_s    = req_valid_s & bus.req_ready;
   assign rd_req_hs_s = req_hs_s & (state_r == RD);
   assign w_hs_s      = bus.w_valid & w_ready_s;
   assign r_hs_s      = r_valid_s & bus.r_ready;
   assign b_hs_s      = b_valid_s & bus.b_ready;

   // Returns are only accepted during a target read; stale returns after a reset are dropped.
   assign fifo_push_s = bus.rsp_valid & (state_r == RD) & ~oor_r;
   assign fifo_pop_s  = r_hs_s & ~oor_r;

   maxigp_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (AXI_DATA_W)
   ) u_rsp_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (fifo_push_s),
      .pop       (fifo_pop_s),
      .push_data (bus.rsp_data),
      .head      (fifo_head_s),
      .empty     (fifo_empty_s)
   );

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decision.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (ar_hs_s) begin
               state_s = RD;
            end else if (aw_hs_s) begin
               state_s = WR;
            end else begin
               state_s = IDLE;
            end
         end
         RD: begin
            if (r_hs_s && (beat_r == len_r)) begin
               state_s = IDLE;
            end else begin
               state_s = RD;
            end
         end
         WR: begin
            if (w_hs_s && (cnt_r == CNT_W'(1))) begin
               state_s = WR_RESP;
            end else begin
               state_s = WR;
            end
         end
         WR_RESP: begin
            if (b_hs_s) begin
               state_s = IDLE;
            end else begin
               state_s = WR_RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Channel outputs per state; readies stay low while reset is asserted.
   always_comb begin
      ar_ready_s  = 1'b0;
      aw_ready_s  = 1'b0;
      r_valid_s   = 1'b0;
      r_last_s    = 1'b0;
      r_resp_s    = RESP_OKAY;
      r_data_s    = '0;
      w_ready_s   = 1'b0;
      b_valid_s   = 1'b0;
      b_resp_s    = RESP_OKAY;
      req_valid_s = 1'b0;
      req_write_s = 1'b0;
      req_wdata_s = '0;
      case (state_r)
         IDLE: begin
            ar_ready_s = ~RST & grant_rd_s;
            aw_ready_s = ~RST & grant_wr_s;
         end
         RD: begin
            r_last_s = (beat_r == len_r);
            if (oor_r) begin
               r_valid_s = 1'b1;
               r_resp_s  = RESP_SLVERR;
               r_data_s  = '0;
            end else begin
               req_valid_s = (cnt_r != '0) && (credits_r != '0);
               r_valid_s   = ~fifo_empty_s;
               r_resp_s    = RESP_OKAY;
               r_data_s    = fifo_head_s;
            end
         end
         WR: begin
            req_write_s = 1'b1;
            req_wdata_s = bus.w_data;
            if (cnt_r == '0) begin
               w_ready_s   = 1'b0;
               req_valid_s = 1'b0;
            end else if (oor_r) begin
               w_ready_s   = 1'b1;
               req_valid_s = 1'b0;
            end else begin
               w_ready_s   = bus.req_ready;
               req_valid_s = bus.w_valid;
            end
         end
         WR_RESP: begin
            b_valid_s = 1'b1;
            b_resp_s  = (err_r | oor_r) ? RESP_SLVERR : RESP_OKAY;
         end
         default: begin
            b_valid_s = 1'b0;
         end
      endcase
   end

   assign bus.ar_ready  = ar_ready_s;
   assign bus.aw_ready  = aw_ready_s;
   assign bus.r_valid   = r_valid_s;
   assign bus.r_data    = r_data_s;
   assign bus.r_id      = id_r;
   assign bus.r_resp    = r_resp_s;
   assign bus.r_last    = r_last_s;
   assign bus.w_ready   = w_ready_s;
   assign bus.b_valid   = b_valid_s;
   assign bus.b_id      = id_r;
   assign bus.b_resp    = b_resp_s;
   assign bus.req_valid = req_valid_s;
   assign bus.req_write = req_write_s;
   assign bus.req_addr  = addr_r;
   assign bus.req_wdata = req_wdata_s;

   // Burst context capture, beat sequencing, credits and write error tracking.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_first_r <= 1'b1;
         addr_r     <= '0;
         id_r       <= '0;
         len_r      <= '0;
         beat_r     <= '0;
         cnt_r      <= '0;
         credits_r  <= CRED_MAX;
         err_r      <= 1'b0;
         oor_r      <= 1'b0;
      end else begin
         if (ar_hs_s) begin
            addr_r     <= bus.ar_addr[ADDR_W+1:2];
            id_r       <= bus.ar_id;
            len_r      <= bus.ar_len;
            cnt_r      <= {1'b0, bus.ar_len} + CNT_W'(1);
            beat_r     <= '0;
            oor_r      <= ar_oor_s;
            rd_first_r <= ~rd_first_r;
         end else if (aw_hs_s) begin
            addr_r     <= bus.aw_addr[ADDR_W+1:2];
            id_r       <= bus.aw_id;
            len_r      <= bus.aw_len;
            cnt_r      <= {1'b0, bus.aw_len} + CNT_W'(1);
            beat_r     <= '0;
            oor_r      <= aw_oor_s;
            err_r      <= 1'b0;
            rd_first_r <= ~rd_first_r;
         end else begin
            if (req_hs_s || w_hs_s) begin
               addr_r <= addr_r + ADDR_W'(1);
               cnt_r  <= cnt_r - CNT_W'(1);
            end
            if ((state_r == WR) && w_hs_s && (bus.w_last != (cnt_r == CNT_W'(1)))) begin
               err_r <= 1'b1;
            end
            if (b_hs_s) begin
               err_r <= 1'b0;
            end
            if (r_hs_s) begin
               beat_r <= beat_r + AXI_LEN_W'(1);
            end
            credits_r <= credits_r + CRED_W'(fifo_pop_s) - CRED_W'(rd_req_hs_s);
         end
      end
   end

endmodule

// File: tb/tb_maxigp_req_scheduler.sv
// Directed self-checking bench for maxigp_req_scheduler with a fixed-latency target model.
module tb_maxigp_req_scheduler;

   logic CLK;
   logic RST;
   int   passed;
   int   total;
   int   tgt_lat;

   typedef struct {
      logic [31:0] data;
      logic [11:0] id;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   typedef struct {
      logic [17:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } req_t;

   rbeat_t r_log[$];
   req_t   req_log[$];

   bit        slot_v [8];
   bit [31:0] slot_d [8];

   maxigp_req_scheduler_if #(.ADDR_W(18), .ID_W(12)) bus ();

   maxigp_req_scheduler #(.ADDR_W(18), .ID_W(12), .RSP_DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Target read data pattern: a fixed word at 0x40, otherwise tagged address.
   function automatic logic [31:0] tgt_data(input logic [17:0] a);
      if (a == 18'h00040) return 32'hA5A5A5A5;
      return {14'h2B3C, a};
   endfunction

   // Target model: returns read data tgt_lat cycles after each accepted read request.
   assign bus.rsp_valid = slot_v[0];
   assign bus.rsp_data  = slot_d[0];
   always @(posedge CLK) begin
      for (int i = 0; i < 7; i++) begin
         slot_v[i] <= slot_v[i+1];
         slot_d[i] <= slot_d[i+1];
      end
      slot_v[7] <= 1'b0;
      if (bus.req_valid && bus.req_ready && !bus.req_write) begin
         slot_v[tgt_lat-1] <= 1'b1;
         slot_d[tgt_lat-1] <= tgt_data(bus.req_addr);
      end
   end

   // Transaction monitors for target requests and R beats.
   always @(posedge CLK) begin
      if (!RST && bus.req_valid && bus.req_ready)
         req_log.push_back('{addr: bus.req_addr, wr: bus.req_write, wdata: bus.req_wdata});
      if (!RST && bus.r_valid && bus.r_ready)
         r_log.push_back('{data: bus.r_data, id: bus.r_id, resp: bus.r_resp, last: bus.r_last});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_rlog(input int n, input string tag);
      int k;
      k = 0;
      while (r_log.size() < n && k < 300) begin
         @(negedge CLK);
         k++;
      end
      check(tag, 32'(r_log.size()), 32'(n));
   endtask

   task automatic drive_ar(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len);
      bus.ar_addr  = a;
      bus.ar_id    = id;
      bus.ar_len   = len;
      bus.ar_valid = 1'b1;
   endtask

   task automatic drive_aw(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len);
      bus.aw_addr  = a;
      bus.aw_id    = id;
      bus.aw_len   = len;
      bus.aw_valid = 1'b1;
   endtask

   task automatic write_beats(input logic [31:0] base, input int n, input int last_at, input string tag);
      for (int i = 0; i < n; i++) begin
         bus.w_data  = base + 32'(i);
         bus.w_last  = (i == last_at);
         bus.w_valid = 1'b1;
         #1 check(tag, 32'(bus.w_ready), 32'd1);
         @(negedge CLK);
      end
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      tgt_lat = 3;
      RST = 1'b1;
      bus.ar_addr = '0; bus.ar_id = '0; bus.ar_len = '0; bus.ar_valid = 1'b1;
      bus.aw_addr = '0; bus.aw_id = '0; bus.aw_len = '0; bus.aw_valid = 1'b1;
      bus.w_data = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
      bus.r_ready = 1'b1; bus.b_ready = 1'b0; bus.req_ready = 1'b1;

      // Reset state, with both address valids held high.
      repeat (3) @(negedge CLK);
      #1;
      check("rst_ar_ready",  32'(bus.ar_ready),  32'd0);
      check("rst_aw_ready",  32'(bus.aw_ready),  32'd0);
      check("rst_r_valid",   32'(bus.r_valid),   32'd0);
      check("rst_b_valid",   32'(bus.b_valid),   32'd0);
      check("rst_b_resp",    32'(bus.b_resp),    32'd0);
      check("rst_r_resp",    32'(bus.r_resp),    32'd0);
      check("rst_req_valid", 32'(bus.req_valid), 32'd0);
      check("rst_w_ready",   32'(bus.w_ready),   32'd0);
      bus.ar_valid = 1'b0;
      bus.aw_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Single read at 0x100, latency 3.
      drive_ar(32'h0000_0100, 12'h005, 4'd0);
      #1 check("t1_ar_ready", 32'(bus.ar_ready), 32'd1);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      #1;
      check("t1_req_valid", 32'(bus.req_valid), 32'd1);
      check("t1_req_addr",  32'(bus.req_addr),  32'h40);
      check("t1_req_write", 32'(bus.req_write), 32'd0);
      wait_rlog(1, "t1_rbeats");
      check("t1_r_data", r_log[0].data,        32'hA5A5A5A5);
      check("t1_r_id",   32'(r_log[0].id),     32'd5);
      check("t1_r_last", 32'(r_log[0].last),   32'd1);
      check("t1_r_resp", 32'(r_log[0].resp),   32'd0);
      check("t1_nreq",   32'(req_log.size()),  32'd1);

      // 16-beat read with R stalled: credits cap issued requests.
      r_log.delete();
      req_log.delete();
      tgt_lat = 2;
      bus.r_ready = 1'b0;
      drive_ar(32'h0000_0200, 12'h0A3, 4'd15);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      repeat (20) @(negedge CLK);
      #1;
      check("t2_credit_nreq", 32'(req_log.size()), 32'd4);
      check("t2_req_held",    32'(bus.req_valid),  32'd0);
      check("t2_r_valid",     32'(bus.r_valid),    32'd1);
      bus.r_ready = 1'b1;
      wait_rlog(16, "t2_rbeats");
      for (int i = 0; i < r_log.size(); i++) begin
         check($sformatf("t2_data%0d", i), r_log[i].data, tgt_data(18'(32'h80 + i)));
         check($sformatf("t2_last%0d", i), 32'(r_log[i].last), 32'(i == 15));
      end
      check("t2_id", 32'(r_log[15].id), 32'h0A3);
      check("t2_nreq", 32'(req_log.size()), 32'd16);
      for (int i = 0; i < req_log.size(); i++) begin
         check($sformatf("t2_addr%0d", i), 32'(req_log[i].addr), 32'h80 + 32'(i));
      end

      // Write burst len=3 wrapping the word address.
      req_log.delete();
      @(negedge CLK);
      drive_aw(32'h000F_FFF8, 12'h007, 4'd3);
      #1 check("t3_aw_ready", 32'(bus.aw_ready), 32'd1);
      @(negedge CLK);
      bus.aw_valid = 1'b0;
      write_beats(32'h0000_1000, 4, 3, "t3_w_ready");
      #1;
      check("t3_b_valid", 32'(bus.b_valid), 32'd1);
      check("t3_b_resp",  32'(bus.b_resp),  32'd0);
      check("t3_b_id",    32'(bus.b_id),    32'd7);
      bus.b_ready = 1'b1;
      @(negedge CLK);
      bus.b_ready = 1'b0;
      #1 check("t3_b_done", 32'(bus.b_valid), 32'd0);
      check("t3_nreq", 32'(req_log.size()), 32'd4);
      check("t3_addr0", 32'(req_log[0].addr), 32'h3FFFE);
      check("t3_addr1", 32'(req_log[1].addr), 32'h3FFFF);
      check("t3_addr2", 32'(req_log[2].addr), 32'h00000);
      check("t3_addr3", 32'(req_log[3].addr), 32'h00001);
      check("t3_wr",    32'(req_log[2].wr),   32'd1);
      check("t3_wdata", req_log[3].wdata,     32'h0000_1003);

      // Same write with w_last on the third beat: SLVERR.
      @(negedge CLK);
      drive_aw(32'h0000_0040, 12'h008, 4'd3);
      @(negedge CLK);
      bus.aw_valid = 1'b0;
      write_beats(32'h0000_2000, 4, 2, "t3e_w_ready");
      #1;
      check("t3e_b_valid", 32'(bus.b_valid), 32'd1);
      check("t3e_b_resp",  32'(bus.b_resp),  32'h2);
      bus.b_ready = 1'b1;
      @(negedge CLK);
      bus.b_ready = 1'b0;

      // Reset in the middle of an 8-beat read.
      r_log.delete();
      drive_ar(32'h0000_0C00, 12'h001, 4'd7);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      wait_rlog(2, "t4_two_beats");
      RST = 1'b1;
      #1;
      check("t4_r_valid",   32'(bus.r_valid),   32'd0);
      check("t4_req_valid", 32'(bus.req_valid), 32'd0);
      check("t4_b_valid",   32'(bus.b_valid),   32'd0);
      check("t4_w_ready",   32'(bus.w_ready),   32'd0);
      check("t4_r_resp",    32'(bus.r_resp),    32'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      r_log.delete();
      drive_ar(32'h0000_0080, 12'h003, 4'd1);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      wait_rlog(2, "t4_new_beats");
      check("t4_data0", r_log[0].data,      tgt_data(18'h20));
      check("t4_data1", r_log[1].data,      tgt_data(18'h21));
      check("t4_last0", 32'(r_log[0].last), 32'd0);
      check("t4_last1", 32'(r_log[1].last), 32'd1);
      repeat (4) @(negedge CLK);
      check("t4_no_extra", 32'(r_log.size()), 32'd2);

      // Simultaneous requests from reset: read first, then write.
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      r_log.delete();
      drive_ar(32'h0000_0140, 12'h009, 4'd0);
      drive_aw(32'h0000_0180, 12'h00A, 4'd0);
      #1;
      check("t5_rd_first_ar", 32'(bus.ar_ready), 32'd1);
      check("t5_rd_first_aw", 32'(bus.aw_ready), 32'd0);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      bus.aw_valid = 1'b0;
      wait_rlog(1, "t5_rbeat");
      check("t5_r_id",   32'(r_log[0].id), 32'd9);
      check("t5_r_data", r_log[0].data,    tgt_data(18'h50));
      drive_ar(32'h0000_01C0, 12'h00B, 4'd0);
      drive_aw(32'h0000_0180, 12'h00A, 4'd0);
      #1;
      check("t5_wr_next_aw", 32'(bus.aw_ready), 32'd1);
      check("t5_wr_next_ar", 32'(bus.ar_ready), 32'd0);
      @(negedge CLK);
      bus.aw_valid = 1'b0;
      bus.w_data  = 32'h0000_5555;
      bus.w_last  = 1'b1;
      bus.w_valid = 1'b1;
      #1 check("t5_ar_wait_wr", 32'(bus.ar_ready), 32'd0);
      @(negedge CLK);
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
      #1;
      check("t5_b_valid",     32'(bus.b_valid),  32'd1);
      check("t5_b_id",        32'(bus.b_id),     32'hA);
      check("t5_ar_wait_rsp", 32'(bus.ar_ready), 32'd0);
      bus.b_ready = 1'b1;
      @(negedge CLK);
      bus.b_ready = 1'b0;
      #1 check("t5_ar_after", 32'(bus.ar_ready), 32'd1);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      wait_rlog(2, "t5_rbeat2");
      check("t5_r_id2",   32'(r_log[1].id), 32'hB);
      check("t5_r_data2", r_log[1].data,    tgt_data(18'h70));

`ifdef MAXIGP_ADDR_DECODE_EN
      // Out-of-range read is answered locally with SLVERR.
      @(negedge CLK);
      r_log.delete();
      req_log.delete();
      drive_ar(32'h0010_0000, 12'h004, 4'd1);
      @(negedge CLK);
      bus.ar_valid = 1'b0;
      wait_rlog(2, "t6_rbeats");
      check("t6_nreq",  32'(req_log.size()),  32'd0);
      check("t6_data0", r_log[0].data,        32'd0);
      check("t6_resp0", 32'(r_log[0].resp),   32'h2);
      check("t6_data1", r_log[1].data,        32'd0);
      check("t6_resp1", 32'(r_log[1].resp),   32'h2);
      check("t6_last1", 32'(r_log[1].last),   32'd1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
